regfile_wb_queue: RTL and testbench

Write-side front end for the CPU register file. It accepts register-write requests over a valid/ready handshake and buffers them in a small in-order FIFO. It drains one entry per cycle into the register file write port (`WE`, `RegWrite`, `Din`), and forwards still-pending data to the two read ports so readers never see stale values. It sits between the writeback stage and the register file in the multi-cycle and pipelined cores.

---
 rtl/wb_pkg.sv | 19 +
 rtl/regfile_wb_queue_if.sv | 33 +++
 rtl/wb_fwd_match.sv | 45 ++++
 rtl/regfile_wb_queue.sv | 132 +++++++++++++
 tb/tb_regfile_wb_queue.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the register-file write-back queue.
// Provides default address/data widths, the $zero register index and
// the {valid, addr, data} entry record layout at the default widths.
package wb_pkg;

  localparam int unsigned WB_AW = 5;
  localparam int unsigned WB_DW = 32;

  // Writes to this register are architecturally discarded.
  localparam logic [WB_AW-1:0] REG_ZERO = '0;

  // Queue entry record at default widths.
  typedef struct packed {
    logic             valid;
    logic [WB_AW-1:0] addr;
    logic [WB_DW-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_wb_queue_if.sv
// Write-request handshake bus from the writeback stage into the queue.
// Signals:
//   in_valid  request present (producer -> queue)
//   in_ready  queue can accept (queue -> producer)
//   in_addr   destination register
//   in_data   write data
interface regfile_wb_queue_if #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 32
);

  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;

  // Producer side (writeback stage).
  modport master (
    output in_valid,
    output in_addr,
    output in_data,
    input  in_ready
  );

  // Consumer side (the queue).
  modport slave (
    input  in_valid,
    input  in_addr,
    input  in_data,
    output in_ready
  );

endinterface

// File: rtl/wb_fwd_match.sv
// Youngest-match lookup over the pending write queue for one read port.
// Ports:
//   valid_i    per-entry valid bits
//   addr_i     per-entry destination register
//   data_i     per-entry write data
//   wp_i       write pointer; the entry just behind it is the youngest
//   rd_addr_i  register currently being read
//   hit_o      some valid entry targets rd_addr_i (never for $zero)
//   data_o     data of the youngest matching entry, 0 when no hit
module wb_fwd_match
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = WB_AW,
  parameter int unsigned DW    = WB_DW
) (
  input  logic [DEPTH-1:0]         valid_i,
  input  logic [AW-1:0]            addr_i [DEPTH],
  input  logic [DW-1:0]            data_i [DEPTH],
  input  logic [$clog2(DEPTH)-1:0] wp_i,
  input  logic [AW-1:0]            rd_addr_i,
  output logic                     hit_o,
  output logic [DW-1:0]            data_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW-1:0] idx;

  // Walk oldest (at wp) to youngest (wp-1); later hits overwrite earlier ones.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = wp_i + PW'(i);
      if (valid_i[idx] && (addr_i[idx] == rd_addr_i) &&
          (rd_addr_i != AW'(REG_ZERO))) begin
        hit_o  = 1'b1;
        data_o = data_i[idx];
      end
    end
  end

endmodule

// File: rtl/regfile_wb_queue.sv
// Write-side front end for the CPU register file.
// Buffers register-write requests in an in-order FIFO, drains one entry per
// cycle into the register file write port, and forwards pending data to the
// two read ports so readers never observe stale register contents.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   req                  write-request handshake (in_valid/in_ready/in_addr/in_data)
//   drain_en             permits draining this cycle
//   WE, RegWrite, Din    register file write port (head of queue)
//   rd_addr1, rd_addr2   addresses presented on the register file read ports
//   fwd_hit*, fwd_data*  forwarding result per read port
//   count, empty, full   occupancy status
module regfile_wb_queue
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = WB_AW,
  parameter int unsigned DW    = WB_DW
) (
  input  logic                   clk,
  input  logic                   rst,
  regfile_wb_queue_if.slave      req,
  input  logic                   drain_en,
  output logic                   WE,
  output logic [AW-1:0]          RegWrite,
  output logic [DW-1:0]          Din,
  input  logic [AW-1:0]          rd_addr1,
  input  logic [AW-1:0]          rd_addr2,
  output logic                   fwd_hit1,
  output logic                   fwd_hit2,
  output logic [DW-1:0]          fwd_data1,
  output logic [DW-1:0]          fwd_data2,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [AW-1:0]    addr_q [DEPTH];
  logic [AW-1:0]    addr_d [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DW-1:0]    data_d [DEPTH];
  logic [PW-1:0]    wp_q, wp_d;
  logic [PW-1:0]    rp_q, rp_d;
  logic [CW-1:0]    count_q, count_d;

  logic push;
  logic pop;

  // Status straight from the registered count; ready does not anticipate a pop.
  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign count        = count_q;
  assign req.in_ready = ~full;

  // $zero writes complete the handshake but are never stored.
  assign push = req.in_valid && !full && (req.in_addr != AW'(REG_ZERO));
  assign pop  = drain_en && !empty;

  // Head entry presented to the register file; zeroed when not writing.
  assign WE       = pop;
  assign RegWrite = pop ? addr_q[rp_q] : '0;
  assign Din      = pop ? data_q[rp_q] : '0;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q + CW'(push) - CW'(pop);

    // Pop and push never target the same slot: equal pointers mean empty or full.
    if (pop) begin
      valid_d[rp_q] = 1'b0;
      rp_d          = rp_q + PW'(1);
    end
    if (push) begin
      valid_d[wp_q] = 1'b1;
      addr_d[wp_q]  = req.in_addr;
      data_d[wp_q]  = req.in_data;
      wp_d          = wp_q + PW'(1);
    end
  end

  // State registers; reset drops every pending entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // One youngest-match lookup per read port.
  wb_fwd_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fwd1 (
    .valid_i   (valid_q),
    .addr_i    (addr_q),
    .data_i    (data_q),
    .wp_i      (wp_q),
    .rd_addr_i (rd_addr1),
    .hit_o     (fwd_hit1),
    .data_o    (fwd_data1)
  );

  wb_fwd_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fwd2 (
    .valid_i   (valid_q),
    .addr_i    (addr_q),
    .data_i    (data_q),
    .wp_i      (wp_q),
    .rd_addr_i (rd_addr2),
    .hit_o     (fwd_hit2),
    .data_o    (fwd_data2)
  );

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Self-checking bench for regfile_wb_queue: accepted writes go into a
// scoreboard queue and are compared in order against register file writes.
module tb_regfile_wb_queue;
  import wb_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = WB_AW;
  localparam int unsigned DW    = WB_DW;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          drain_en;
  logic          WE;
  logic [AW-1:0] RegWrite;
  logic [DW-1:0] Din;
  logic [AW-1:0] rd_addr1, rd_addr2;
  logic          fwd_hit1, fwd_hit2;
  logic [DW-1:0] fwd_data1, fwd_data2;
  logic [CW-1:0] count;
  logic          empty, full;

  int checks = 0;
  int errors = 0;

  wb_entry_t sb[$];
  wb_entry_t exp_e;

  regfile_wb_queue_if #(.AW(AW), .DW(DW)) req_if ();

  regfile_wb_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req_if),
    .drain_en  (drain_en),
    .WE        (WE),
    .RegWrite  (RegWrite),
    .Din       (Din),
    .rd_addr1  (rd_addr1),
    .rd_addr2  (rd_addr2),
    .fwd_hit1  (fwd_hit1),
    .fwd_hit2  (fwd_hit2),
    .fwd_data1 (fwd_data1),
    .fwd_data2 (fwd_data2),
    .count     (count),
    .empty     (empty),
    .full      (full)
  );

  always #5 clk = ~clk;

  // Every register file write must match the oldest outstanding accepted request.
  always @(negedge clk) begin
    if (WE === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected got r%0d=%h, none pending", RegWrite, Din);
      end else begin
        exp_e = sb.pop_front();
        if (RegWrite !== exp_e.addr || Din !== exp_e.data) begin
          errors++;
          $display("FAIL wb_order got r%0d=%h exp r%0d=%h", RegWrite, Din, exp_e.addr, exp_e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_if.in_valid = v;
    req_if.in_addr  = a;
    req_if.in_data  = d;
  endtask

  task automatic expect_push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wb_entry_t e;
    e.valid = 1'b1;
    e.addr  = a;
    e.data  = d;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drain_en = 1'b1;
    rd_addr1 = AW'(3);
    rd_addr2 = AW'(4);
    drive(1'b0, '0, '0);
    step();
    step();
    checks++;
    if ({req_if.in_ready, empty, full, WE} !== 4'b1100) begin
      errors++;
      $display("FAIL reset_status got rdy/emp/full/we=%b exp 1100", {req_if.in_ready, empty, full, WE});
    end
    checks++;
    if (RegWrite !== '0 || Din !== '0 || count !== '0) begin
      errors++;
      $display("FAIL reset_port got r%0d=%h count=%0d exp 0", RegWrite, Din, count);
    end
    checks++;
    if ({fwd_hit1, fwd_hit2} !== 2'b00 || fwd_data1 !== '0 || fwd_data2 !== '0) begin
      errors++;
      $display("FAIL reset_fwd got hits=%b d1=%h d2=%h exp 0", {fwd_hit1, fwd_hit2}, fwd_data1, fwd_data2);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_fill();
    drain_en = 1'b0;
    rd_addr1 = AW'(3);
    drive(1'b1, AW'(3), DW'(32'h11)); expect_push(AW'(3), DW'(32'h11)); step();
    drive(1'b1, AW'(4), DW'(32'h22)); expect_push(AW'(4), DW'(32'h22)); step();
    drive(1'b0, '0, '0);
    #1;
    checks++;
    if (count !== CW'(2) || fwd_hit1 !== 1'b1 || fwd_data1 !== DW'(32'h11)) begin
      errors++;
      $display("FAIL midfill_pre got count=%0d hit=%b d=%h exp 2 1 11", count, fwd_hit1, fwd_data1);
    end
    rst = 1'b1;
    drain_en = 1'b1;
    sb.delete();
    #1;
    checks++;
    if (count !== '0 || WE !== 1'b0 || fwd_hit1 !== 1'b0) begin
      errors++;
      $display("FAIL midfill_rst got count=%0d we=%b hit=%b exp 0 0 0", count, WE, fwd_hit1);
    end
    step();
    rst = 1'b0;
    step(); step(); step();
    checks++;
    if (empty !== 1'b1 || WE !== 1'b0) begin
      errors++;
      $display("FAIL midfill_post got empty=%b we=%b exp 1 0", empty, WE);
    end
  endtask

  task automatic test_fill_full();
    drain_en = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, AW'(i), DW'(32'hA0 + i));
      expect_push(AW'(i), DW'(32'hA0 + i));
      step();
    end
    drive(1'b1, AW'(5), DW'(32'hA5));
    #1;
    checks++;
    if (full !== 1'b1 || req_if.in_ready !== 1'b0 || count !== CW'(4)) begin
      errors++;
      $display("FAIL full_flag got full=%b rdy=%b count=%0d exp 1 0 4", full, req_if.in_ready, count);
    end
    step();
    checks++;
    if (count !== CW'(4)) begin
      errors++;
      $display("FAIL full_refuse got count=%0d exp 4", count);
    end
    // Still full at the start of the first drain cycle: r5 must be refused.
    drain_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (WE !== 1'b1) begin
        errors++;
        $display("FAIL drain_we cycle %0d got we=%b exp 1", i, WE);
      end
      step();
      drive(1'b0, '0, '0);
    end
    checks++;
    if (empty !== 1'b1 || count !== '0) begin
      errors++;
      $display("FAIL drain_empty got empty=%b count=%0d exp 1 0", empty, count);
    end
  endtask

  task automatic test_forward();
    drain_en = 1'b0;
    rd_addr1 = AW'(7);
    rd_addr2 = AW'(8);
    drive(1'b1, AW'(7), DW'(32'h100)); expect_push(AW'(7), DW'(32'h100)); step();
    drive(1'b1, AW'(7), DW'(32'h200)); expect_push(AW'(7), DW'(32'h200)); step();
    drive(1'b0, '0, '0);
    #1;
    checks++;
    if (fwd_hit1 !== 1'b1 || fwd_data1 !== DW'(32'h200)) begin
      errors++;
      $display("FAIL fwd_youngest got hit=%b d=%h exp 1 200", fwd_hit1, fwd_data1);
    end
    checks++;
    if (fwd_hit2 !== 1'b0 || fwd_data2 !== '0) begin
      errors++;
      $display("FAIL fwd_miss got hit=%b d=%h exp 0 0", fwd_hit2, fwd_data2);
    end
    rd_addr2 = AW'(7);
    drain_en = 1'b1;
    #1;
    checks++;
    if (WE !== 1'b1 || fwd_hit2 !== 1'b1 || fwd_data2 !== DW'(32'h200)) begin
      errors++;
      $display("FAIL fwd_head_drain got we=%b hit=%b d=%h exp 1 1 200", WE, fwd_hit2, fwd_data2);
    end
    step();
    checks++;
    if (fwd_hit1 !== 1'b1 || fwd_data1 !== DW'(32'h200)) begin
      errors++;
      $display("FAIL fwd_after_pop got hit=%b d=%h exp 1 200", fwd_hit1, fwd_data1);
    end
    step();
    checks++;
    if (fwd_hit1 !== 1'b0 || fwd_data1 !== '0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL fwd_drained got hit=%b d=%h empty=%b exp 0 0 1", fwd_hit1, fwd_data1, empty);
    end
  endtask

  task automatic test_zero_reg();
    drain_en = 1'b1;
    rd_addr1 = AW'(0);
    drive(1'b1, AW'(0), DW'(32'hDEAD));
    #1;
    checks++;
    if (req_if.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL zero_ready got rdy=%b exp 1", req_if.in_ready);
    end
    step();
    drive(1'b0, '0, '0);
    checks++;
    if (count !== '0 || empty !== 1'b1 || fwd_hit1 !== 1'b0) begin
      errors++;
      $display("FAIL zero_discard got count=%0d empty=%b hit=%b exp 0 1 0", count, empty, fwd_hit1);
    end
    step(); step();
  endtask

  task automatic test_back_to_back();
    int over;
    over = 0;
    drain_en = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      drive(1'b1, AW'(i), DW'(32'h1000 + i));
      expect_push(AW'(i), DW'(32'h1000 + i));
      step();
      checks++;
      if (count > CW'(1)) begin
        errors++;
        $display("FAIL b2b_count push %0d got count=%0d exp <=1", i, count);
      end
    end
    drive(1'b0, '0, '0);
    step(); step();
    checks++;
    if (empty !== 1'b1 || sb.size() != 0) begin
      errors++;
      $display("FAIL b2b_done got empty=%b pending=%0d exp 1 0", empty, sb.size());
    end
  endtask

  task automatic test_drain_hold();
    drain_en = 1'b0;
    rd_addr1 = AW'(10);
    rd_addr2 = AW'(9);
    drive(1'b1, AW'(9),  DW'(32'h55)); expect_push(AW'(9),  DW'(32'h55)); step();
    drive(1'b1, AW'(10), DW'(32'h66)); expect_push(AW'(10), DW'(32'h66)); step();
    drive(1'b0, '0, '0);
    drain_en = 1'b1;
    #1;
    checks++;
    if (WE !== 1'b1 || RegWrite !== AW'(9)) begin
      errors++;
      $display("FAIL hold_first got we=%b r%0d exp 1 r9", WE, RegWrite);
    end
    step();
    drain_en = 1'b0;
    #1;
    checks++;
    if (WE !== 1'b0 || count !== CW'(1) || fwd_hit1 !== 1'b1 || fwd_data1 !== DW'(32'h66) || fwd_hit2 !== 1'b0) begin
      errors++;
      $display("FAIL hold_freeze got we=%b count=%0d hit1=%b d1=%h hit2=%b exp 0 1 1 66 0",
               WE, count, fwd_hit1, fwd_data1, fwd_hit2);
    end
    step();
    drain_en = 1'b1;
    #1;
    checks++;
    if (WE !== 1'b1 || RegWrite !== AW'(10) || Din !== DW'(32'h66)) begin
      errors++;
      $display("FAIL hold_resume got we=%b r%0d=%h exp 1 r10=66", WE, RegWrite, Din);
    end
    step();
    checks++;
    if (empty !== 1'b1 || fwd_hit1 !== 1'b0) begin
      errors++;
      $display("FAIL hold_empty got empty=%b hit=%b exp 1 0", empty, fwd_hit1);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_fill();
    test_fill_full();
    test_forward();
    test_zero_reg();
    test_back_to_back();
    test_drain_hold();
    step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got %0d pending exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
